// File: rtl/ball_pkg.sv
// Shared types and constants for the bouncing-ball controller.
// Config macro: BALL_POP_BLINK_EN adds the POPPING blink state.
package ball_pkg;
    // Position is unsigned Q11.6, speed is signed 1/64 px per frame
    localparam int FRAC_W = 6;
    localparam int POS_W  = 17;
    localparam int INT_W  = POS_W - FRAC_W;
    localparam int SPD_W  = 12;
    localparam int SPD_MAX = 2047;

    localparam int DEF_OBJECT_SIZE  = 70;
    localparam int DEF_X_SPEED      = 96;
    localparam int DEF_GRAVITY      = 8;
    localparam int DEF_BOUNCE_SPEED = 640;

`ifdef BALL_POP_BLINK_EN
    localparam int POP_FRAMES = 16;
    typedef enum logic [1:0] {IDLE, ACTIVE, POPPING} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif
endpackage

// File: rtl/square_window.sv
// Pixel-in-box test and pixel offset, one registered stage.
module square_window
    import ball_pkg::*;
#(
    parameter int OBJECT_SIZE = DEF_OBJECT_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INT_W-1:0] pixelX,
    input  logic [INT_W-1:0] pixelY,
    input  logic [INT_W-1:0] topLeftX,
    input  logic [INT_W-1:0] topLeftY,
    output logic [INT_W-1:0] offsetX,
    output logic [INT_W-1:0] offsetY,
    output logic             InsideRectangle
);
    logic w_inX, w_inY;

    // One extra bit keeps topLeft + size from wrapping near the screen edge
    assign w_inX = ({1'b0, pixelX} >= {1'b0, topLeftX}) &&
                   ({1'b0, pixelX} <  ({1'b0, topLeftX} + (INT_W+1)'(OBJECT_SIZE)));
    assign w_inY = ({1'b0, pixelY} >= {1'b0, topLeftY}) &&
                   ({1'b0, pixelY} <  ({1'b0, topLeftY} + (INT_W+1)'(OBJECT_SIZE)));

    // Register hit flag and offsets so both arrive one cycle after the pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            InsideRectangle <= w_inX && w_inY;
            offsetX         <= pixelX - topLeftX;
            offsetY         <= pixelY - topLeftY;
        end
    end
endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball physics: spawn, per-frame motion with gravity, floor bounce,
// wall reflection and pop on hit. Config macro: BALL_POP_BLINK_EN.
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int OBJECT_SIZE  = DEF_OBJECT_SIZE,
    parameter int LEFT_WALL    = 0,
    parameter int RIGHT_WALL   = 639,
    parameter int FLOOR_Y      = 479,
    parameter int X_SPEED      = DEF_X_SPEED,
    parameter int GRAVITY      = DEF_GRAVITY,
    parameter int BOUNCE_SPEED = DEF_BOUNCE_SPEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startOfFrame,
    input  logic [INT_W-1:0] pixelX,
    input  logic [INT_W-1:0] pixelY,
    input  logic             spawn,
    input  logic [INT_W-1:0] spawnX,
    input  logic [INT_W-1:0] spawnY,
    input  logic             spawnDirRight,
    input  logic             hit,
    output logic [INT_W-1:0] offsetX,
    output logic [INT_W-1:0] offsetY,
    output logic             InsideRectangle,
    output logic             visible,
    output logic [INT_W-1:0] topLeftX,
    output logic [INT_W-1:0] topLeftY,
    output logic             popped
);
    localparam logic [INT_W-1:0] LEFT_POS  = INT_W'(LEFT_WALL);
    localparam logic [INT_W-1:0] RIGHT_POS = INT_W'(RIGHT_WALL - OBJECT_SIZE + 1);
    localparam logic [INT_W-1:0] FLOOR_POS = INT_W'(FLOOR_Y - OBJECT_SIZE + 1);

    state_t                  r_state;
    logic [POS_W-1:0]        r_posX, r_posY;
    logic signed [SPD_W-1:0] r_speedX, r_speedY;
    logic                    r_visible, r_popped;
`ifdef BALL_POP_BLINK_EN
    logic [3:0]              r_popCnt;
    logic [3:0]              w_popCntNext;
    assign w_popCntNext = r_popCnt + 4'd1;
`endif

    logic [POS_W-1:0]        w_xSum, w_ySum;
    logic [INT_W-1:0]        w_xInt, w_yInt;
    logic                    w_xUnder, w_hitLeft, w_hitRight, w_hitFloor;
    logic signed [SPD_W:0]   w_spdYSum;
    logic signed [SPD_W-1:0] w_spdYNext;

    assign w_xSum = r_posX + {{(POS_W-SPD_W){r_speedX[SPD_W-1]}}, r_speedX};
    assign w_ySum = r_posY + {{(POS_W-SPD_W){r_speedY[SPD_W-1]}}, r_speedY};
    assign w_xInt = w_xSum[POS_W-1:FRAC_W];
    assign w_yInt = w_ySum[POS_W-1:FRAC_W];

    // Moving left and landing above the old position means x went below 0
    assign w_xUnder   = r_speedX[SPD_W-1] && (w_xSum > r_posX);
    assign w_hitLeft  = w_xUnder || ({2'b00, w_xInt} < 13'(LEFT_WALL));
    assign w_hitRight = ({2'b00, w_xInt} + 13'(OBJECT_SIZE - 1)) > 13'(RIGHT_WALL);

    // Gravity with saturation; gravity is positive so only the top can overflow
    assign w_spdYSum  = {r_speedY[SPD_W-1], r_speedY} + (SPD_W+1)'(GRAVITY);
    assign w_spdYNext = (w_spdYSum > (SPD_W+1)'(SPD_MAX)) ? SPD_W'(SPD_MAX)
                                                          : w_spdYSum[SPD_W-1:0];
    assign w_hitFloor = (({2'b00, w_yInt} + 13'(OBJECT_SIZE - 1)) >= 13'(FLOOR_Y)) &&
                        (w_spdYNext > 0);

    assign topLeftX = r_posX[POS_W-1:FRAC_W];
    assign topLeftY = r_posY[POS_W-1:FRAC_W];
    assign visible  = r_visible;
    assign popped   = r_popped;

    // Ball state machine; hit has priority over the frame's physics update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_posX    <= '0;
            r_posY    <= '0;
            r_speedX  <= '0;
            r_speedY  <= '0;
            r_visible <= 1'b0;
            r_popped  <= 1'b0;
`ifdef BALL_POP_BLINK_EN
            r_popCnt  <= '0;
`endif
        end else begin
            r_popped <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (spawn) begin
                        r_posX    <= {spawnX, {FRAC_W{1'b0}}};
                        r_posY    <= {spawnY, {FRAC_W{1'b0}}};
                        r_speedX  <= spawnDirRight ? SPD_W'(X_SPEED) : -SPD_W'(X_SPEED);
                        r_speedY  <= '0;
                        r_visible <= 1'b1;
                        r_state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (hit) begin
                        r_popped  <= 1'b1;
                        r_visible <= 1'b0;
`ifdef BALL_POP_BLINK_EN
                        r_popCnt  <= '0;
                        r_state   <= POPPING;
`else
                        r_state   <= IDLE;
`endif
                    end else if (startOfFrame) begin
                        if (w_hitLeft) begin
                            r_posX   <= {LEFT_POS, {FRAC_W{1'b0}}};
                            r_speedX <= -r_speedX;
                        end else if (w_hitRight) begin
                            r_posX   <= {RIGHT_POS, {FRAC_W{1'b0}}};
                            r_speedX <= -r_speedX;
                        end else begin
                            r_posX   <= w_xSum;
                        end
                        if (w_hitFloor) begin
                            r_posY   <= {FLOOR_POS, {FRAC_W{1'b0}}};
                            r_speedY <= -SPD_W'(BOUNCE_SPEED);
                        end else begin
                            r_posY   <= w_ySum;
                            r_speedY <= w_spdYNext;
                        end
                    end
                end
`ifdef BALL_POP_BLINK_EN
                POPPING: begin
                    if (startOfFrame) begin
                        if (r_popCnt == 4'(POP_FRAMES - 1)) begin
                            r_visible <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_popCnt  <= w_popCntNext;
                            r_visible <= w_popCntNext[2];
                        end
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    square_window #(.OBJECT_SIZE(OBJECT_SIZE)) u_window (
        .clk             (clk),
        .reset           (reset),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .topLeftX        (topLeftX),
        .topLeftY        (topLeftY),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle)
    );
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl (default parameters).
module tb_ball_motion_ctrl;
`ifdef BALL_POP_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    localparam int SZ = 70;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0, pixelY = '0;
    logic        spawn = 1'b0;
    logic [10:0] spawnX = '0, spawnY = '0;
    logic        spawnDirRight = 1'b0;
    logic        hit = 1'b0;
    logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
    logic        InsideRectangle, visible, popped;

    ball_motion_ctrl dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .spawn(spawn),
        .spawnX(spawnX), .spawnY(spawnY), .spawnDirRight(spawnDirRight),
        .hit(hit), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle), .visible(visible),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .popped(popped)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int vis; int pop; } exp_t;
    typedef struct { int ins; int ox; int oy; } wexp_t;
    exp_t  q[$];
    wexp_t wq[$];

    int n_chk = 0, n_fail = 0;
    // model: positions and speeds in 1/64 px, state 0 idle / 1 active / 2 popping
    int mx = 0, my = 0, msx = 0, msy = 0, mst = 0, mcnt = 0, mvis = 0, mpop = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        mx = 0; my = 0; msx = 0; msy = 0; mst = 0; mcnt = 0; mvis = 0; mpop = 0;
    endtask

    task automatic model_frame();
        if (mst == 1) begin
            mx = mx + msx;
            if (mx < 0) begin
                mx = 0; msx = -msx;
            end else if ((mx >>> 6) + SZ - 1 > 639) begin
                mx = (639 - SZ + 1) * 64; msx = -msx;
            end
            my = my + msy;
            msy = msy + 8;
            if (msy > 2047) msy = 2047;
            if ((my >>> 6) + SZ - 1 >= 479 && msy > 0) begin
                my = (479 - SZ + 1) * 64; msy = -640;
            end
        end else if (mst == 2) begin
            mcnt++;
            if (mcnt == 16) begin mst = 0; mvis = 0; end
            else mvis = (mcnt / 4) % 2;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.x = mx >>> 6; e.y = my >>> 6; e.vis = mvis; e.pop = mpop;
        mpop = 0;
        q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        e = q.pop_front();
        chk({tag, ".x"},   int'(topLeftX), e.x);
        chk({tag, ".y"},   int'(topLeftY), e.y);
        chk({tag, ".vis"}, int'(visible),  e.vis);
        chk({tag, ".pop"}, int'(popped),   e.pop);
    endtask

    task automatic do_frame();
        startOfFrame = 1'b1;
        model_frame();
        push_exp();
        tick();
        startOfFrame = 1'b0;
        check_out("frame");
        tick();
    endtask

    task automatic do_spawn(input int x, input int y, input bit right);
        spawn = 1'b1; spawnX = 11'(x); spawnY = 11'(y); spawnDirRight = right;
        if (mst == 0) begin
            mx = x * 64; my = y * 64; msx = right ? 96 : -96; msy = 0;
            mst = 1; mvis = 1;
        end
        push_exp();
        tick();
        spawn = 1'b0;
        check_out("spawn");
    endtask

    task automatic do_hit(input bit sof);
        hit = 1'b1; startOfFrame = sof;
        if (mst == 1) begin
            mpop = 1; mvis = 0; mcnt = 0;
            mst = BLINK ? 2 : 0;
        end else if (sof) begin
            model_frame();
        end
        push_exp();
        tick();
        hit = 1'b0; startOfFrame = 1'b0;
        check_out("hit");
        push_exp();
        tick();
        check_out("hit_after");
    endtask

    task automatic do_pix(input int px, input int py);
        wexp_t w;
        int tx, ty;
        tx = mx >>> 6; ty = my >>> 6;
        pixelX = 11'(px); pixelY = 11'(py);
        w.ins = (px >= tx && px < tx + SZ && py >= ty && py < ty + SZ) ? 1 : 0;
        w.ox = px - tx; w.oy = py - ty;
        wq.push_back(w);
        tick();
        w = wq.pop_front();
        chk("win.ins", int'(InsideRectangle), w.ins);
        if (w.ins == 1) begin
            chk("win.ox", int'(offsetX), w.ox);
            chk("win.oy", int'(offsetY), w.oy);
        end
    endtask

    initial begin
        bit seen;
        // reset state
        tick(); tick();
        chk("rst.vis", int'(visible), 0);
        chk("rst.x", int'(topLeftX), 0);
        chk("rst.y", int'(topLeftY), 0);
        chk("rst.pop", int'(popped), 0);
        chk("rst.ins", int'(InsideRectangle), 0);
        reset = 1'b0;
        model_reset();
        tick();

        // spawn right, first frame truncates 1.5 px to 101
        do_spawn(100, 100, 1'b1);
        do_frame();
        chk("first.x", int'(topLeftX), 101);
        chk("first.vis", int'(visible), 1);
        for (int i = 0; i < 20; i++) do_frame();

        // spawn while active is ignored
        do_spawn(10, 10, 1'b0);
        do_frame();

        // hit coinciding with a frame: position frozen
        do_hit(1'b1);
        for (int i = 0; i < 18; i++) do_frame();

        // drop onto the floor
        do_spawn(300, 400, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            do_frame();
            if (topLeftY == 11'd410) begin
                seen = 1'b1;
                do_frame();
                chk("bounce.rise", int'(topLeftY), 400);
            end
        end
        chk("bounce.seen", int'(seen), 1);
        do_hit(1'b0);
        for (int i = 0; i < 17; i++) do_frame();

        // right wall
        do_spawn(568, 200, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            do_frame();
            if (topLeftX == 11'd570) begin
                seen = 1'b1;
                do_frame();
                chk("wall.back", int'(topLeftX), 568);
            end
        end
        chk("wall.seen", int'(seen), 1);
        do_hit(1'b0);
        for (int i = 0; i < 17; i++) do_frame();

        // left wall through underflow
        do_spawn(2, 300, 1'b0);
        for (int i = 0; i < 8; i++) do_frame();
        do_hit(1'b0);
        for (int i = 0; i < 17; i++) do_frame();

        // window stage
        do_spawn(200, 150, 1'b1);
        do_pix(200, 150);
        do_pix(270, 150);
        do_pix(269, 219);
        do_pix(199, 150);
        do_pix(200, 220);
        do_pix(235, 180);

        // random spawns and flights
        for (int r = 0; r < 3; r++) begin
            do_hit(1'b0);
            for (int i = 0; i < 17; i++) do_frame();
            do_spawn(int'($urandom_range(0, 560)), int'($urandom_range(0, 400)),
                     1'($urandom_range(0, 1)));
            for (int i = 0; i < 40; i++) do_frame();
            do_pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
        end

        // async reset in the middle of a flight (or blink)
        do_hit(1'b0);
        do_frame();
        do_frame();
        #2 reset = 1'b1;
        #1;
        chk("arst.vis", int'(visible), 0);
        chk("arst.x", int'(topLeftX), 0);
        chk("arst.pop", int'(popped), 0);
        model_reset();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) do_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
